// File: rtl/hazard_pkg.sv
// Forwarding-select encodings shared by the hazard controller and its users.
package hazard_pkg;

    typedef enum logic [1:0] {
        FW_NONE_E = 2'b00,
        FW_W_E    = 2'b01,
        FW_M_E    = 2'b10
    } fwd_e_t;

    typedef enum logic {
        FW_NONE_D = 1'b0,
        FW_M_D    = 1'b1
    } fwd_d_t;

endpackage

// File: rtl/hazard_unit_md_busy_tracker.sv
// HI/LO occupancy tracker: busy for exactly LAT cycles from the MULT/DIV issue cycle.
// A new issue restarts the count; a pipeline flush only suppresses a same-cycle issue.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start_e,
    input  logic md_is_div_e,
    input  logic exc_flush,
    output logic md_busy
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic             start;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign start = md_start_e & ~exc_flush;

    // The issue cycle itself counts as busy, so the counter holds LAT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = md_is_div_e ? DIV_LOAD : MUL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = rst_n & ((cnt_q != '0) | start);

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use/branch/HI-LO stalls, flushes.
// Define HAZARD_MULDIV_EN to build the MULT/DIV occupancy tracker and the HI/LO stall.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic              branch_d,
    input  logic              hilo_use_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] reg_addr_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    input  logic [REG_AW-1:0] reg_addr_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic [REG_AW-1:0] reg_addr_w,
    input  logic              reg_write_w,
    input  logic              exc_flush,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    // $zero is hardwired, so it can never be a real producer.
    function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    fwd_e_t      sel_a_e;
    fwd_e_t      sel_b_e;
    logic        src_hit_e;
    logic        src_hit_m;
    logic        load_use;
    logic        branch_stall;
    logic        hilo_stall;
    logic        stall_any;
    logic        stall;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    always_comb begin
        sel_a_e = FW_NONE_E;
        sel_b_e = FW_NONE_E;
        if (reg_write_m && hit(reg_addr_m, rs_e)) begin
            sel_a_e = FW_M_E;
        end else if (reg_write_w && hit(reg_addr_w, rs_e)) begin
            sel_a_e = FW_W_E;
        end
        if (reg_write_m && hit(reg_addr_m, rt_e)) begin
            sel_b_e = FW_M_E;
        end else if (reg_write_w && hit(reg_addr_w, rt_e)) begin
            sel_b_e = FW_W_E;
        end
    end

    assign fwd_a_e = rst_n ? sel_a_e : FW_NONE_E;
    assign fwd_b_e = rst_n ? sel_b_e : FW_NONE_E;

    assign fwd_a_d = rst_n & reg_write_m & ~mem_to_reg_m & use_rs_d & hit(reg_addr_m, rs_d);
    assign fwd_b_d = rst_n & reg_write_m & ~mem_to_reg_m & use_rt_d & hit(reg_addr_m, rt_d);

    assign src_hit_e = (use_rs_d & hit(reg_addr_e, rs_d)) | (use_rt_d & hit(reg_addr_e, rt_d));
    assign src_hit_m = (use_rs_d & hit(reg_addr_m, rs_d)) | (use_rt_d & hit(reg_addr_m, rt_d));

    assign load_use     = mem_to_reg_e & src_hit_e;
    assign branch_stall = branch_d & ((reg_write_e & src_hit_e) | (mem_to_reg_m & src_hit_m));

`ifdef HAZARD_MULDIV_EN
    logic md_busy_int;

    md_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .exc_flush   (exc_flush),
        .md_busy     (md_busy_int)
    );

    assign hilo_stall = hilo_use_d & md_busy_int;
    assign md_busy    = md_busy_int;
`else
    logic unused_md;
    localparam int unused_lat = MUL_LAT + DIV_LAT;

    assign unused_md  = ^{md_start_e, md_is_div_e, hilo_use_d};
    assign hilo_stall = 1'b0;
    assign md_busy    = 1'b0;
`endif

    // A taken exception discards the younger instructions, so holding them is pointless.
    assign stall_any = load_use | branch_stall | hilo_stall;
    assign stall     = rst_n & stall_any & ~exc_flush;

    assign stall_pc     = stall;
    assign stall_if_id  = stall;
    assign flush_id_ex  = stall | (rst_n & exc_flush);
    assign flush_if_id  = rst_n & exc_flush;
    assign flush_ex_mem = rst_n & exc_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = rst_n ? stall_cnt_q : '0;

endmodule
